// File: rtl/mio_mem_if.sv
// mio_mem_if
// Bundles the CPU data-side MIO bus signals between the CPU core (master)
// and a memory responder (slave).
//   CPU_MIO   : memory request, level, held until MIO_ready is seen
//   mem_w     : 1 = write, 0 = read, qualified by CPU_MIO
//   Addr_out  : CPU byte address
//   Data_out  : CPU write data
//   Data_in   : read data returned to the CPU
//   MIO_ready : one-cycle completion pulse
//   INT       : sticky interrupt request
//   int_ack   : interrupt acknowledge, clears INT
//   busy      : responder has a transaction in flight
//   err       : error flag, valid together with MIO_ready
interface mio_mem_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic              CPU_MIO;
  logic              mem_w;
  logic [ADDR_W-1:0] Addr_out;
  logic [DATA_W-1:0] Data_out;
  logic [DATA_W-1:0] Data_in;
  logic              MIO_ready;
  logic              INT;
  logic              int_ack;
  logic              busy;
  logic              err;

  modport master (
    output CPU_MIO, mem_w, Addr_out, Data_out, int_ack,
    input  Data_in, MIO_ready, INT, busy, err
  );

  modport slave (
    input  CPU_MIO, mem_w, Addr_out, Data_out, int_ack,
    output Data_in, MIO_ready, INT, busy, err
  );
endinterface

// File: rtl/mio_mem_responder.sv
// mio_mem_responder
// Data-memory responder for the CPU MIO bus, used for CPU bring-up and
// simulation. Accepts one request at a time, answers after LATENCY wait
// cycles with a one-cycle MIO_ready pulse, and raises a periodic sticky
// interrupt when INT_PERIOD is non-zero.
// Ports:
//   clk   : clock, rising edge
//   reset : synchronous reset, active-low
//   bus   : mio_mem_if slave modport (CPU_MIO, mem_w, Addr_out, Data_out,
//           int_ack in; Data_in, MIO_ready, INT, busy, err out)
module mio_mem_responder #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 32,
  parameter int DEPTH      = 1024,
  parameter int LATENCY    = 2,
  parameter int INT_PERIOD = 0
) (
  input  logic    clk,
  input  logic    reset,
  mio_mem_if.slave bus
);

  localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int WIDX_W = ADDR_W - 2;
  localparam int CNT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [WIDX_W-1:0] DEPTH_LIM = WIDX_W'(DEPTH);
  localparam logic [CNT_W-1:0]  CNT_INIT  = (LATENCY > 0) ? CNT_W'(LATENCY - 1) : {CNT_W{1'b0}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Misaligned addresses and word indices beyond the RAM both fault.
  function automatic logic addr_fault(input logic [ADDR_W-1:0] a);
    addr_fault = (a[1:0] != 2'b00) || (a[ADDR_W-1:2] >= DEPTH_LIM);
  endfunction

  logic [DATA_W-1:0] mem_r [DEPTH];

  state_t            state_r, state_nxt_s;
  logic [CNT_W-1:0]  cnt_r, cnt_nxt_s;
  logic [ADDR_W-1:0] addr_r;
  logic              we_r;
  logic [DATA_W-1:0] wdata_r;

  logic              ready_r, ready_nxt_s;
  logic              err_r, err_nxt_s;
  logic              busy_r, busy_nxt_s;
  logic [DATA_W-1:0] rdata_r, rdata_nxt_s;
  logic              int_r;

  logic              accept_s;
  logic              resp_entry_s;
  logic [ADDR_W-1:0] req_addr_s;
  logic              req_we_s;
  logic [DATA_W-1:0] req_wdata_s;
  logic              req_err_s;
  logic [IDX_W-1:0]  idx_s;
  logic              ram_we_s;

  assign accept_s = (state_r == ST_IDLE) && bus.CPU_MIO;

  // With LATENCY=0 the response is produced on the accept edge itself, so
  // the request is taken straight from the bus while idle and from the
  // latched copy otherwise.
  always_comb begin
    req_addr_s  = addr_r;
    req_we_s    = we_r;
    req_wdata_s = wdata_r;
    if (state_r == ST_IDLE) begin
      req_addr_s  = bus.Addr_out;
      req_we_s    = bus.mem_w;
      req_wdata_s = bus.Data_out;
    end else begin
      req_addr_s  = addr_r;
      req_we_s    = we_r;
      req_wdata_s = wdata_r;
    end
  end

  assign req_err_s    = addr_fault(req_addr_s);
  assign idx_s        = req_addr_s[IDX_W+1:2];
  // RESP never persists, so any move into RESP is an entry.
  assign resp_entry_s = (state_nxt_s == ST_RESP);
  assign ram_we_s     = resp_entry_s && req_we_s && !req_err_s;

  // State, wait counter, latched request and registered outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r <= ST_IDLE;
      cnt_r   <= {CNT_W{1'b0}};
      addr_r  <= {ADDR_W{1'b0}};
      we_r    <= 1'b0;
      wdata_r <= {DATA_W{1'b0}};
      ready_r <= 1'b0;
      err_r   <= 1'b0;
      busy_r  <= 1'b0;
      rdata_r <= {DATA_W{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      ready_r <= ready_nxt_s;
      err_r   <= err_nxt_s;
      busy_r  <= busy_nxt_s;
      rdata_r <= rdata_nxt_s;
      if (accept_s) begin
        addr_r  <= bus.Addr_out;
        we_r    <= bus.mem_w;
        wdata_r <= bus.Data_out;
      end
    end
  end

  // Next-state and wait-count logic.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.CPU_MIO) begin
          if (LATENCY > 0) begin
            state_nxt_s = ST_WAIT;
            cnt_nxt_s   = CNT_INIT;
          end else begin
            state_nxt_s = ST_RESP;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_r == {CNT_W{1'b0}}) begin
          state_nxt_s = ST_RESP;
        end else begin
          cnt_nxt_s = cnt_r - CNT_W'(1);
        end
      end
      ST_RESP: begin
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
        cnt_nxt_s   = {CNT_W{1'b0}};
      end
    endcase
  end

  // Next values of the registered bus outputs.
  always_comb begin
    ready_nxt_s = resp_entry_s;
    err_nxt_s   = resp_entry_s && req_err_s;
    busy_nxt_s  = (state_nxt_s != ST_IDLE);
    rdata_nxt_s = rdata_r;
    if (resp_entry_s && !req_we_s) begin
      if (req_err_s) begin
        rdata_nxt_s = {DATA_W{1'b0}};
      end else begin
        rdata_nxt_s = mem_r[idx_s];
      end
    end else begin
      rdata_nxt_s = rdata_r;
    end
  end

  // RAM write port; reset on the same edge blocks a pending write.
  always_ff @(posedge clk) begin
    if (reset && ram_we_s) begin
      mem_r[idx_s] <= req_wdata_s;
    end
  end

  generate
    if (INT_PERIOD > 0) begin : g_int
      localparam int IW = (INT_PERIOD > 1) ? $clog2(INT_PERIOD) : 1;
      localparam logic [IW-1:0] ILAST = IW'(INT_PERIOD - 1);
      logic [IW-1:0] int_cnt_r;
      logic          wrap_s;

      assign wrap_s = (int_cnt_r == ILAST);

      // Free-running interrupt timer; a wrap sets INT and beats a same-edge ack.
      always_ff @(posedge clk) begin
        if (!reset) begin
          int_cnt_r <= {IW{1'b0}};
          int_r     <= 1'b0;
        end else begin
          if (wrap_s) begin
            int_cnt_r <= {IW{1'b0}};
            int_r     <= 1'b1;
          end else begin
            int_cnt_r <= int_cnt_r + IW'(1);
            if (bus.int_ack) begin
              int_r <= 1'b0;
            end
          end
        end
      end
    end else begin : g_no_int
      // Interrupts disabled: INT is held low.
      always_ff @(posedge clk) begin
        int_r <= 1'b0;
      end
    end
  endgenerate

  assign bus.Data_in   = rdata_r;
  assign bus.MIO_ready = ready_r;
  assign bus.err       = err_r;
  assign bus.busy      = busy_r;
  assign bus.INT       = int_r;

endmodule
